// File: rtl/azpr_rst_pkg.sv
// Shared types and helpers for the AZPR reset sequencer.
package azpr_rst_pkg;

    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        REL_BUS = 3'd1,
        REL_PER = 3'd2,
        RUN     = 3'd3,
        DRAIN   = 3'd4,
        GATED   = 3'd5
    } rst_state_e;

    // Counter width large enough to hold the longest of the three intervals.
    function automatic int ctr_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/azpr_rst_timer.sv
// Up-counter shared by every sequencer state: clear on state entry,
// count while enabled, flag when the current terminal value is reached.
module azpr_rst_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         at_limit
);

    logic [W-1:0] count;

    // Clear has priority; the owner clears on every state change so the count never wraps.
    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/azpr_reset_sequencer.sv
// Staged reset release (bus, peripheral, CPU) followed by ownership of the
// downstream clock enable: drain on idle sleep request, gate, restore on wake.
module azpr_reset_sequencer
    import azpr_rst_pkg::*;
#(
    parameter int RESET_HOLD = 4,
    parameter int STAGE_GAP  = 2,
    parameter int GATE_DELAY = 8
) (
    input  logic system_clock,
    input  logic reset,
    input  logic sleep_req,
    input  logic wake_req,
    input  logic bus_idle,
    output logic bus_reset,
    output logic periph_reset,
    output logic cpu_reset,
    output logic ck_en,
    output logic rst_done,
    output logic seq_err
);

    localparam int CW = ctr_width(RESET_HOLD, STAGE_GAP, GATE_DELAY);
    localparam logic [CW-1:0] HOLD_TC = CW'(RESET_HOLD - 1);
    localparam logic [CW-1:0] GAP_TC  = CW'(STAGE_GAP - 1);
    // The RUN->DRAIN edge already consumed one idle cycle, so DRAIN needs one fewer.
    localparam logic [CW-1:0] DRAIN_TC = CW'((GATE_DELAY >= 2) ? (GATE_DELAY - 2) : 0);

    rst_state_e      state;
    rst_state_e      next_state;
    logic            at_limit;
    logic            timer_clr;
    logic            timer_en;
    logic [CW-1:0]   timer_limit;

    azpr_rst_timer #(.W(CW)) u_timer (
        .clk      (system_clock),
        .clr      (timer_clr),
        .en       (timer_en),
        .limit    (timer_limit),
        .at_limit (at_limit)
    );

    // Next-state and timer control; the timer restarts from zero on every state change.
    always_comb begin
        next_state  = state;
        timer_en    = 1'b0;
        timer_limit = HOLD_TC;
        case (state)
            HOLD: begin
                timer_en    = 1'b1;
                timer_limit = HOLD_TC;
                if (at_limit) next_state = REL_BUS;
            end
            REL_BUS: begin
                timer_en    = 1'b1;
                timer_limit = GAP_TC;
                if (at_limit) next_state = REL_PER;
            end
            REL_PER: begin
                timer_en    = 1'b1;
                timer_limit = GAP_TC;
                if (at_limit) next_state = RUN;
            end
            RUN: begin
                if (sleep_req && bus_idle && !wake_req) begin
                    if (GATE_DELAY == 1)
                        next_state = GATED;
                    else
                        next_state = DRAIN;
                end
            end
            DRAIN: begin
                timer_en    = bus_idle;
                timer_limit = DRAIN_TC;
                // Any reason to abandon the drain takes precedence over gating.
                if (!bus_idle || !sleep_req || wake_req)
                    next_state = RUN;
                else if (at_limit)
                    next_state = GATED;
            end
            GATED: begin
                if (wake_req) next_state = RUN;
            end
            default: next_state = HOLD;
        endcase
        timer_clr = reset || (next_state != state);
    end

    // State and registered outputs, all derived from the state being entered.
    always_ff @(posedge system_clock) begin
        if (reset) begin
            state        <= HOLD;
            bus_reset    <= 1'b1;
            periph_reset <= 1'b1;
            cpu_reset    <= 1'b1;
            ck_en        <= 1'b1;
            rst_done     <= 1'b0;
            seq_err      <= 1'b0;
        end else begin
            state        <= next_state;
            bus_reset    <= (next_state == HOLD);
            periph_reset <= (next_state inside {HOLD, REL_BUS});
            cpu_reset    <= (next_state inside {HOLD, REL_BUS, REL_PER});
            rst_done     <= !(next_state inside {HOLD, REL_BUS, REL_PER});
            ck_en        <= (next_state != GATED);
            // A sleep request while domains are still held in reset is a sequencing error.
            if (sleep_req && (state inside {HOLD, REL_BUS, REL_PER}))
                seq_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_azpr_reset_sequencer.sv
// Self-checking bench for azpr_reset_sequencer with an edge-count reference model.
module tb_azpr_reset_sequencer;

    localparam int RH = 4;
    localparam int SG = 2;
    localparam int GD = 8;

    logic system_clock = 1'b0;
    logic reset = 1'b1;
    logic sleep_req = 1'b0;
    logic wake_req = 1'b0;
    logic bus_idle = 1'b0;
    logic bus_reset, periph_reset, cpu_reset, ck_en, rst_done, seq_err;

    int checks = 0;
    int errors = 0;

    // Reference model: edges since reset release, consecutive qualifying sleep edges, gated flag.
    int   m_n = 0;
    int   m_streak = 0;
    bit   m_gated = 1'b0;
    bit   m_seq = 1'b0;

    logic [5:0] obs;
    assign obs = {bus_reset, periph_reset, cpu_reset, ck_en, rst_done, seq_err};

    azpr_reset_sequencer #(
        .RESET_HOLD (RH),
        .STAGE_GAP  (SG),
        .GATE_DELAY (GD)
    ) dut (
        .system_clock (system_clock),
        .reset        (reset),
        .sleep_req    (sleep_req),
        .wake_req     (wake_req),
        .bus_idle     (bus_idle),
        .bus_reset    (bus_reset),
        .periph_reset (periph_reset),
        .cpu_reset    (cpu_reset),
        .ck_en        (ck_en),
        .rst_done     (rst_done),
        .seq_err      (seq_err)
    );

    always #5 system_clock = ~system_clock;

    function automatic logic [5:0] expv();
        return {logic'(m_n < RH), logic'(m_n < RH + SG), logic'(m_n < RH + 2*SG),
                logic'(!m_gated), logic'(m_n >= RH + 2*SG), logic'(m_seq)};
    endfunction

    // Apply inputs, advance one edge, update the model, then settle before sampling.
    task automatic tick(input bit r, input bit s, input bit w, input bit i);
        bit done_before;
        reset = r; sleep_req = s; wake_req = w; bus_idle = i;
        @(posedge system_clock);
        if (r) begin
            m_n = 0; m_streak = 0; m_gated = 1'b0; m_seq = 1'b0;
        end else begin
            done_before = (m_n >= RH + 2*SG);
            if (!done_before && s) m_seq = 1'b1;
            if (done_before) begin
                if (m_gated) begin
                    if (w) begin m_gated = 1'b0; m_streak = 0; end
                end else if (s && i && !w) begin
                    m_streak++;
                    if (m_streak >= GD) begin m_gated = 1'b1; m_streak = 0; end
                end else begin
                    m_streak = 0;
                end
            end
            if (m_n < 1000) m_n++;
        end
        #1;
    endtask

    task automatic test_reset();
        int first_bus, first_per, first_cpu;
        first_bus = -1; first_per = -1; first_cpu = -1;
        for (int k = 0; k < 10; k++) begin
            tick(1, 0, 0, 0);
            checks++;
            if (obs !== 6'b111100) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%b want=111100", k, obs);
            end
        end
        for (int k = 1; k <= 12; k++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL release k=%0d got=%b want=%b", k, obs, expv());
            end
            if (first_bus < 0 && bus_reset === 1'b0) first_bus = k;
            if (first_per < 0 && periph_reset === 1'b0) first_per = k;
            if (first_cpu < 0 && cpu_reset === 1'b0 && rst_done === 1'b1) first_cpu = k;
        end
        checks++;
        if (first_bus != RH) begin
            errors++; $display("FAIL bus_release_edge got=%0d want=%0d", first_bus, RH);
        end
        checks++;
        if (first_per != RH + SG) begin
            errors++; $display("FAIL per_release_edge got=%0d want=%0d", first_per, RH + SG);
        end
        checks++;
        if (first_cpu != RH + 2*SG) begin
            errors++; $display("FAIL cpu_release_edge got=%0d want=%0d", first_cpu, RH + 2*SG);
        end
    endtask

    task automatic test_sleep_gate();
        for (int k = 1; k <= GD + 3; k++) begin
            tick(0, 1, 0, 1);
            checks++;
            if (obs !== expv() || ck_en !== logic'(k < GD)) begin
                errors++;
                $display("FAIL sleep_gate k=%0d got=%b want=%b ck_en_want=%0d", k, obs, expv(), k < GD);
            end
        end
        tick(0, 1, 1, 1);
        checks++;
        if (obs !== expv() || ck_en !== 1'b1) begin
            errors++; $display("FAIL wake got=%b want=%b", obs, expv());
        end
        tick(0, 0, 0, 1);
        checks++;
        if (obs !== expv()) begin
            errors++; $display("FAIL after_wake got=%b want=%b", obs, expv());
        end
    endtask

    task automatic test_drain_abort();
        for (int k = 1; k <= 5; k++) tick(0, 1, 0, 1);
        tick(0, 1, 0, 0);
        checks++;
        if (obs !== expv() || ck_en !== 1'b1) begin
            errors++; $display("FAIL drain_abort got=%b want=%b", obs, expv());
        end
        for (int k = 1; k <= GD; k++) begin
            tick(0, 1, 0, 1);
            checks++;
            if (obs !== expv() || ck_en !== logic'(k < GD)) begin
                errors++;
                $display("FAIL resleep k=%0d got=%b want=%b", k, obs, expv());
            end
        end
        tick(0, 0, 1, 0);
        checks++;
        if (obs !== expv() || ck_en !== 1'b1) begin
            errors++; $display("FAIL drain_wake got=%b want=%b", obs, expv());
        end
    endtask

    task automatic test_sleep_wake_same();
        for (int k = 1; k <= GD + 4; k++) begin
            tick(0, 1, 1, 1);
            checks++;
            if (obs !== expv() || ck_en !== 1'b1) begin
                errors++; $display("FAIL sleep_wake k=%0d got=%b want=%b", k, obs, expv());
            end
        end
    endtask

    task automatic test_seq_err();
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            tick(0, (k <= 2), 0, 0);
            checks++;
            if (obs !== expv() || seq_err !== 1'b1) begin
                errors++; $display("FAIL seq_err k=%0d got=%b want=%b", k, obs, expv());
            end
        end
    endtask

    task automatic test_reset_gated();
        for (int k = 1; k <= GD; k++) tick(0, 1, 0, 1);
        checks++;
        if (ck_en !== 1'b0) begin
            errors++; $display("FAIL pre_gated ck_en got=%b want=0", ck_en);
        end
        tick(1, 1, 0, 1);
        checks++;
        if (obs !== 6'b111100) begin
            errors++; $display("FAIL reset_gated got=%b want=111100", obs);
        end
        for (int k = 1; k <= 10; k++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (obs !== expv()) begin
                errors++; $display("FAIL rerelease k=%0d got=%b want=%b", k, obs, expv());
            end
        end
    endtask

    task automatic test_random();
        bit r, s, w, i;
        for (int k = 0; k < 600; k++) begin
            r = ($urandom_range(0, 59) == 0);
            s = ($urandom_range(0, 9) < 8);
            w = ($urandom_range(0, 19) == 0);
            i = ($urandom_range(0, 19) < 18);
            tick(r, s, w, i);
            checks++;
            if (obs !== expv()) begin
                errors++; $display("FAIL random k=%0d got=%b want=%b", k, obs, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sleep_gate();
        test_drain_abort();
        test_sleep_wake_same();
        test_seq_err();
        test_reset_gated();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
